// File: rtl/dac_prog_rx.sv
// dac_prog_rx
// Chip-side receiver for the serial-strobe DAC programming interface.
// Keeps one sign+magnitude word per channel and drives all of them,
// flattened, to the per-channel DACs. While the programming window
// (sel_ext_addr) is open, the external channel address is forwarded.
// Every interface input is asynchronous and passes through its own
// synchronizer chain.
//
// Optional feature macro: DAC_READBACK_EN (adds rd_ch/rd_word readback)
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   sel_ext_addr  programming / external-addressing window (async)
//   dac_stb       strobe: rise latches address, fall latches value (async)
//   dac_data      address in the address phase, magnitude in the value phase
//   dac_sgn       sign of the value (0 = electrons)
//   dac_cfg       channel k word at [6k+5:6k] = {sgn,mag}
//   ext_addr_en   synchronized sel_ext_addr
//   ext_addr      forwarded external channel address
//   wr_pulse      one-cycle pulse on each committed write
//   addr_err      one-cycle pulse, address out of range, write discarded
//   abort_err     one-cycle pulse, window closed with strobe high
//   cfg_valid     sticky, all channels written at least once
//   rd_ch/rd_word channel readback, 1-cycle latency (DAC_READBACK_EN only)
module dac_prog_rx #(
  parameter int         N_CH        = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] RST_WORD    = 6'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_ext_addr,
  input  logic              dac_stb,
  input  logic [4:0]        dac_data,
  input  logic              dac_sgn,
  output logic [N_CH*6-1:0] dac_cfg,
  output logic              ext_addr_en,
  output logic [3:0]        ext_addr,
  output logic              wr_pulse,
  output logic              addr_err,
  output logic              abort_err,
  output logic              cfg_valid
`ifdef DAC_READBACK_EN
  ,
  input  logic [3:0]        rd_ch,
  output logic [5:0]        rd_word
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  localparam logic [4:0] N_CH_W = 5'(N_CH);

  // Synchronizer chain, bundle order {sel, stb, sgn, data[4:0]}
  logic [7:0] sync_q [SYNC_STAGES];
  logic       sel_s;
  logic       stb_s;
  logic       sgn_s;
  logic [4:0] data_s;

  assign {sel_s, stb_s, sgn_s, data_s} = sync_q[SYNC_STAGES-1];

  state_t              state_q, state_d;
  logic                stb_prev_q;
  logic [4:0]          addr_q, addr_d;
  logic [N_CH*6-1:0]   cfg_q, cfg_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic [3:0]          ext_addr_q, ext_addr_d;
  logic                wr_q, wr_d;
  logic                aerr_q, aerr_d;
  logic                abort_q, abort_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                stb_rise_s;
  logic                stb_fall_s;

  assign stb_rise_s = stb_s & ~stb_prev_q;
  assign stb_fall_s = ~stb_s & stb_prev_q;

  // Shift every interface input through the synchronizer stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
    end else begin
      sync_q[0] <= {sel_ext_addr, dac_stb, dac_sgn, dac_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // State, channel words, written mask and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stb_prev_q  <= 1'b0;
      addr_q      <= 5'd0;
      cfg_q       <= {N_CH{RST_WORD}};
      mask_q      <= '0;
      ext_addr_q  <= 4'd0;
      wr_q        <= 1'b0;
      aerr_q      <= 1'b0;
      abort_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_prev_q  <= stb_s;
      addr_q      <= addr_d;
      cfg_q       <= cfg_d;
      mask_q      <= mask_d;
      ext_addr_q  <= ext_addr_d;
      wr_q        <= wr_d;
      aerr_q      <= aerr_d;
      abort_q     <= abort_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  // Next-state, write commit and pulse generation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cfg_d       = cfg_q;
    mask_d      = mask_q;
    wr_d        = 1'b0;
    aerr_d      = 1'b0;
    abort_d     = 1'b0;
    ext_addr_d  = ext_addr_q;
    // One cycle behind the mask so the flag trails the last write
    cfg_valid_d = cfg_valid_q | (&mask_q);

    case (state_q)
      IDLE: begin
        // Entering with the strobe already high would latch a half strobe
        if (sel_s && !stb_s) state_d = ADDR;
        else                 state_d = IDLE;
      end
      ADDR: begin
        if (stb_rise_s) begin
          addr_d = data_s;
          if (data_s >= N_CH_W) begin
            aerr_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DATA;
          end
        end else if (!sel_s) begin
          state_d = IDLE;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        // A strobe fall wins over a simultaneous window close
        if (stb_fall_s) begin
          for (int k = 0; k < N_CH; k++) begin
            if (addr_q == 5'(k)) begin
              cfg_d[6*k +: 6] = {sgn_s, data_s};
              mask_d[k]       = 1'b1;
            end else begin
              mask_d[k] = mask_d[k];
            end
          end
          wr_d = 1'b1;
          if (sel_s) state_d = DONE;
          else       state_d = IDLE;
        end else if (!sel_s) begin
          abort_d = stb_s;
          state_d = IDLE;
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        // Only one write per window; wait for the window to close
        if (!sel_s) state_d = IDLE;
        else        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Live address before the address strobe, latched address after it
    if (sel_s) begin
      if (state_q == IDLE || state_q == ADDR) ext_addr_d = data_s[3:0];
      else                                    ext_addr_d = addr_q[3:0];
    end else begin
      ext_addr_d = ext_addr_q;
    end
  end

  assign dac_cfg     = cfg_q;
  assign ext_addr_en = sel_s;
  assign ext_addr    = ext_addr_q;
  assign wr_pulse    = wr_q;
  assign addr_err    = aerr_q;
  assign abort_err   = abort_q;
  assign cfg_valid   = cfg_valid_q;

`ifdef DAC_READBACK_EN
  logic [5:0] rd_word_q;
  logic [5:0] rd_word_d;

  // Readback mux; out-of-range channels read as zero
  always_comb begin
    rd_word_d = 6'h00;
    for (int k = 0; k < N_CH; k++) begin
      if (rd_ch == 4'(k)) rd_word_d = cfg_q[6*k +: 6];
      else                rd_word_d = rd_word_d;
    end
  end

  // Readback register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_word_q <= 6'h00;
    else        rd_word_q <= rd_word_d;
  end

  assign rd_word = rd_word_q;
`endif

endmodule
